// File: rtl/fifo_par_ser_drain_if.sv
// fifo_par_ser_drain_if: FIFO-side and serial-side signals of the drain stage
interface fifo_par_ser_drain_if #(
  parameter int WIDTH = 32
);
  logic             empty;
  logic [WIDTH-1:0] fifo_data;
  logic             read;
  logic             ser_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;
  modport master (
    input  empty, fifo_data, ser_ready,
    output read, ser_out, ser_valid, ser_first, ser_last, busy
  );
  modport slave (
    output empty, fifo_data, ser_ready,
    input  read, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/fifo_par_ser_drain.sv
// fifo_par_ser_drain: pops FIFO words and shifts them out MSB first; define PAR_SER_PARITY_EN to append an even-parity bit
module fifo_par_ser_drain #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6
) (
  input logic                 clk,
  input logic                 rst,
  fifo_par_ser_drain_if.master bus
);
`ifdef PAR_SER_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FW - 1);
  typedef enum logic [1:0] {IDLE, REQ, CAPT, SHIFT} state_t;
  state_t               state, state_nx;
  logic [FW-1:0]        shreg, load;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 last;
`ifdef PAR_SER_PARITY_EN
  assign load = {bus.fifo_data, ^bus.fifo_data};
`else
  assign load = bus.fifo_data;
`endif
  assign last = cnt == LAST;
  // empty only matters in IDLE and on the edge that accepts the final frame bit
  always_comb begin
    state_nx = state == IDLE ? (bus.empty ? IDLE : REQ) :
               state == REQ  ? CAPT :
               state == CAPT ? SHIFT :
               (bus.ser_ready && last) ? (bus.empty ? IDLE : REQ) : SHIFT;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // load the word one cycle after the pop, then shift on each accepted bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == CAPT) begin
      shreg <= load;
      cnt   <= '0;
    end else if (state == SHIFT && bus.ser_ready && !last) begin
      shreg <= shreg << 1;
      cnt   <= cnt + 1'b1;
    end
  end
  assign bus.read      = state == REQ;
  assign bus.ser_valid = state == SHIFT;
  assign bus.ser_out   = bus.ser_valid & shreg[FW-1];
  assign bus.ser_first = bus.ser_valid & (cnt == '0);
  assign bus.ser_last  = bus.ser_valid & last;
  assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_fifo_par_ser_drain.sv
// tb_fifo_par_ser_drain: FIFO model plus frame scoreboard around the drain stage
module tb_fifo_par_ser_drain;
  localparam int W = 32;
`ifdef PAR_SER_PARITY_EN
  localparam int FW = W + 1;
`else
  localparam int FW = W;
`endif
  localparam int P = FW - W;
  logic clk = 0;
  logic rst = 1;
  int nchk = 0;
  int nfail = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] popped[$];
  fifo_par_ser_drain_if #(.WIDTH(W)) bus ();
  fifo_par_ser_drain #(.WIDTH(W), .CNT_WIDTH(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // FIFO model: data appears the edge after read is sampled, empty is registered
  initial begin
    bus.empty <= 1'b1;
    bus.fifo_data <= '0;
    forever begin
      @(posedge clk);
      if (bus.read) begin
        chk("no_underflow", fq.size() == 0, 0);
        if (fq.size() != 0) begin
          bus.fifo_data <= fq[0];
          popped.push_back(fq[0]);
          void'(fq.pop_front());
        end
      end
      bus.empty <= fq.size() == 0;
    end
  end
  // scoreboard: every popped word must appear as a frame, MSB first, parity last
  initial begin
    int widx, bi;
    logic prev_read;
    logic [W-1:0] w;
    logic eb;
    widx = 0;
    bi = 0;
    prev_read = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        widx = popped.size();
        bi = 0;
        prev_read = 0;
        chk("rst_outputs", {bus.read, bus.ser_out, bus.ser_valid, bus.ser_first, bus.ser_last, bus.busy}, 0);
      end else begin
        if (prev_read) chk("read_one_cycle", bus.read, 0);
        prev_read = bus.read;
        if (bus.ser_valid) begin
          if (widx >= popped.size()) chk("frame_has_word", 0, 1);
          else begin
            w = popped[widx];
            eb = bi < W ? w[W-1-bi] : ^w;
            chk("ser_out", bus.ser_out, eb);
            chk("ser_first", bus.ser_first, bi == 0);
            chk("ser_last", bus.ser_last, bi == FW - 1);
            chk("busy_in_frame", bus.busy, 1);
            if (bus.ser_ready) begin
              bi++;
              if (bi == FW) begin
                bi = 0;
                widx++;
              end
            end
          end
        end else chk("idle_flags", {bus.ser_out, bus.ser_first, bus.ser_last}, 0);
      end
    end
  end
  task automatic wait_read(input string nm);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.read && g < 20);
    chk(nm, bus.read, 1);
  endtask
  task automatic get_frame(input int stall_at, input int stall_len, output logic [63:0] bits, output int n, output int gap);
    int st, guard;
    logic [2:0] held;
    bits = 0;
    n = 0;
    gap = 0;
    st = 0;
    guard = 0;
    held = 0;
    while (n < FW && guard < 300) begin
      @(negedge clk);
      guard++;
      if (!bus.ser_valid) begin
        if (n == 0) gap++;
        else chk("frame_continuous", 0, 1);
      end else if (n == stall_at && st <= stall_len) begin
        if (st == 0) held = {bus.ser_out, bus.ser_first, bus.ser_last};
        else chk("stall_hold", {bus.ser_out, bus.ser_first, bus.ser_last}, held);
        if (st < stall_len) bus.ser_ready = 0;
        else begin
          bus.ser_ready = 1;
          bits = {bits[62:0], bus.ser_out};
          n++;
        end
        st++;
      end else begin
        bus.ser_ready = 1;
        bits = {bits[62:0], bus.ser_out};
        n++;
      end
    end
    if (guard >= 300) chk("frame_timeout", n, FW);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, bench required to finish earlier");
    $fatal(1);
  end
  initial begin
    logic [63:0] bits;
    int n, gap, g;
    bus.ser_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    fq.push_back(32'hFFFF_AAAA);
    wait_read("t1_read");
    get_frame(-1, 0, bits, n, gap);
    chk("t1_latency", gap + 1, 2);
    chk("t1_len", n, FW);
    chk("t1_data", bits[P +: 32], 32'hFFFF_AAAA);
    @(negedge clk);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_read", bus.read, 0);
    fq.push_back(32'hFFFF_AAAA);
    fq.push_back(32'h0000_5555);
    wait_read("t2_read");
    get_frame(-1, 0, bits, n, gap);
    chk("t2_data1", bits[P +: 32], 32'hFFFF_AAAA);
    get_frame(-1, 0, bits, n, gap);
    chk("t2_gap", gap, 2);
    chk("t2_len2", n, FW);
    chk("t2_data2", bits[P +: 32], 32'h0000_5555);
    fq.push_back(32'hA5A5_0F0F);
    wait_read("t3_read");
    get_frame(7, 5, bits, n, gap);
    chk("t3_len", n, FW);
    chk("t3_data", bits[P +: 32], 32'hA5A5_0F0F);
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("t4_quiet", {bus.read, bus.ser_valid, bus.busy}, 0);
    end
    fq.push_back(32'hDEAD_BEEF);
    wait_read("t5_read");
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.ser_valid && g < 20);
    chk("t5_valid", bus.ser_valid, 1);
    repeat (12) @(negedge clk);
    fq.push_back(32'h1234_5678);
    #2 rst = 1;
    #1 chk("t5_async", {bus.read, bus.ser_out, bus.ser_valid, bus.ser_first, bus.ser_last, bus.busy}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("t5_read_after_rst", bus.read, 1);
    get_frame(-1, 0, bits, n, gap);
    chk("t5_gap", gap, 1);
    chk("t5_data", bits[P +: 32], 32'h1234_5678);
`ifdef PAR_SER_PARITY_EN
    fq.push_back(32'h0000_0007);
    fq.push_back(32'h0000_0003);
    wait_read("t6_read");
    get_frame(-1, 0, bits, n, gap);
    chk("t6_len", n, 33);
    chk("t6_frame7", bits[32:0], 33'h0_0000_000F);
    get_frame(-1, 0, bits, n, gap);
    chk("t6_frame3", bits[32:0], 33'h0_0000_0006);
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/fifo_par_ser_drain.md
Name: fifo_par_ser_drain

Overview:
Downstream drain stage for the 32-bit FIFO buffer. It pops one word at a time from the FIFO using a single-cycle read pulse. It captures the FIFO's registered read data and shifts the word out serially, MSB first, under a valid/ready handshake. This is the mirror of the serial-to-parallel front end, and it closes the serial -> FIFO -> serial path on the read clock domain.

Parameters:
- WIDTH, 32: word width of FIFO data and of the shift register.
- CNT_WIDTH, 6: bit-counter width. Must satisfy 2^CNT_WIDTH > WIDTH, so the count can reach WIDTH when the parity bit is enabled.

Ports:
- clk  input  1  read-domain clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO registered read data. Valid the cycle after the edge that samples read=1.
- read  output  1  FIFO pop request, registered, exactly one cycle wide per word.
- ser_ready  input  1  downstream accepts the current serial bit at posedge when high.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a frame bit.
- ser_first  output  1  high with the first bit of a frame.
- ser_last  output  1  high with the final bit of a frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; read, ser_out, ser_valid, ser_first, ser_last, busy all 0.
  - Shift register and counter cleared.
  - A partly shifted word is discarded. It is not re-read.
- States: IDLE, REQ, CAPT, SHIFT. All outputs are registered or decoded from registered state only.
- IDLE:
  - If empty=0 at posedge: read<=1, go to REQ.
  - Otherwise stay in IDLE.
- REQ (read=1 for this one cycle):
  - At the next posedge: read<=0, go to CAPT.
  - The FIFO updates fifo_data on this same edge.
- CAPT:
  - At posedge: shreg<=fifo_data, cnt<=0, go to SHIFT.
  - Latency from the edge raising read to the first valid serial bit is 2 clocks.
- SHIFT:
  - ser_valid=1 and ser_out=shreg[WIDTH-1].
  - ser_first=1 when cnt==0.
  - ser_last=1 when cnt==WIDTH-1 (or cnt==WIDTH with parity enabled).
  - At posedge with ser_ready=1:
    - Not the last bit: shreg<=shreg<<1 and cnt<=cnt+1.
    - Last bit, empty=0: read<=1, go to REQ (back-to-back word).
    - Last bit, empty=1: go to IDLE.
  - At posedge with ser_ready=0: stall. ser_out, ser_valid, ser_first, ser_last, shreg and cnt all hold.
- Inter-word gap: exactly 2 cycles with ser_valid=0 (REQ and CAPT) between the last bit of one word and the first bit of the next.
- Empty handling:
  - empty is sampled only in IDLE and on the last-bit edge.
  - It is ignored in REQ, CAPT and mid-word.
  - read is never asserted while empty=1 is sampled, so the block cannot underflow the FIFO.
- Counter arithmetic: cnt is unsigned and never wraps; it is reset to 0 on every CAPT load.
- ser_ready=0 during IDLE, REQ or CAPT has no effect.

Optional Feature:
- Macro: PAR_SER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra frame bit is sent: the even parity (XOR reduction) of the captured word.
  - The parity bit is latched at CAPT.
  - ser_last moves from the last data bit to the parity bit, making the frame WIDTH+1 bits.
  - The parity bit obeys the same stall rules as data bits.
- Undefined: frames are exactly WIDTH bits, with no parity logic or storage.

Test Plan:
- Reset, FIFO holds 32'hFFFF_AAAA, empty=0, ser_ready=1 -> read is one cycle wide.
  - First ser_valid bit occurs 2 cycles after read rises.
  - Serial stream is 16 ones then 1010... ×8.
  - ser_first on bit 0, ser_last on bit 31, then IDLE with busy=0.
- Two words 32'hFFFF_AAAA and 32'h0000_5555 queued -> second read issued on the last-bit edge of word 1.
  - Exactly 2 ser_valid=0 cycles separate the frames.
  - Second stream is 16 zeros then 0101... ×8.
- ser_ready held low for 5 cycles at bit 7 -> ser_out/ser_first/ser_last stable throughout; the stream resumes intact with 32 bits total.
- empty=1 permanently -> read never asserted; ser_valid=0 and busy=0 for 100 cycles.
- rst pulsed at bit 12 of 32'hDEAD_BEEF with empty=0 afterwards -> outputs go to 0 asynchronously, the partial word is dropped, and a fresh read is issued 1 cycle after rst falls.
- With PAR_SER_PARITY_EN: 32'h0000_0007 -> 33-bit frame whose parity bit is 1 and carries ser_last. 32'h0000_0003 -> parity bit 0.
